// File: rtl/xilly_accel_pkg.sv
// xilly_accel_pkg
// Shared definitions for the Xillybus <-> accelerator bridge:
//   - byte addresses of the control/status register file
//   - bit positions inside the CTRL register
//   - a byte-lane extraction helper used by the read multiplexer
package xilly_accel_pkg;

  localparam logic [31:0] ADDR_CTRL      = 32'd0;
  localparam logic [31:0] ADDR_SELECT    = 32'd1;
  localparam logic [31:0] ADDR_ACK       = 32'd2;
  localparam logic [31:0] ADDR_IN_BEATS  = 32'd4;
  localparam logic [31:0] ADDR_OUT_BEATS = 32'd8;
  localparam logic [31:0] ADDR_SCRATCH   = 32'd12;

  localparam int CTRL_RESTART_BIT = 0;
  localparam int CTRL_CLEAR_BIT   = 1;

  // Little-endian byte lane of a 32-bit word.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/xilly_accel_bridge_if.sv
// xilly_accel_bridge_if
// Bundles every non-clock signal of the bridge: Xillybus mem port, select
// handshake, input FIFO / accelerator input stream, accelerator output /
// output FIFO stream.
//   slave  : the bridge's view
//   master : the surrounding environment's view (Xillybus core + accelerator)
interface xilly_accel_bridge_if #(
  parameter int ADDR_W = 5,
  parameter int PIX_W  = 24
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [7:0]        mem_wdata;
  logic              mem_rden;
  logic [7:0]        mem_rdata;
  logic              accel_reset;
  logic              sel_valid;
  logic              sel_ready;
  logic [7:0]        sel_bits;
  logic              in_fifo_valid;
  logic [31:0]       in_fifo_data;
  logic              in_fifo_rd;
  logic              acc_in_valid;
  logic              acc_in_ready;
  logic [PIX_W-1:0]  acc_in_bits;
  logic              acc_out_valid;
  logic              acc_out_ready;
  logic [PIX_W-1:0]  acc_out_bits;
  logic              out_fifo_full;
  logic              out_fifo_wren;
  logic [31:0]       out_fifo_data;

  modport slave (
    input  mem_addr, mem_wren, mem_wdata, mem_rden,
    output mem_rdata,
    output accel_reset,
    output sel_valid, sel_bits,
    input  sel_ready,
    input  in_fifo_valid, in_fifo_data,
    output in_fifo_rd,
    output acc_in_valid, acc_in_bits,
    input  acc_in_ready,
    input  acc_out_valid, acc_out_bits,
    output acc_out_ready,
    input  out_fifo_full,
    output out_fifo_wren, out_fifo_data
  );

  modport master (
    output mem_addr, mem_wren, mem_wdata, mem_rden,
    input  mem_rdata,
    input  accel_reset,
    input  sel_valid, sel_bits,
    output sel_ready,
    output in_fifo_valid, in_fifo_data,
    input  in_fifo_rd,
    input  acc_in_valid, acc_in_bits,
    output acc_in_ready,
    output acc_out_valid, acc_out_bits,
    input  acc_out_ready,
    output out_fifo_full,
    input  out_fifo_wren, out_fifo_data
  );
endinterface

// File: rtl/xilly_beat_counter.sv
// xilly_beat_counter
// CNT_W-bit wrapping beat counter with synchronous clear and a read snapshot.
// Ports:
//   bus_clk, reset_n : clock, synchronous active-low reset
//   clr              : clear counter (wins over inc)
//   inc              : count one beat
//   snap             : capture the live count into the shadow (low byte read)
//   count_lo         : live count bits [7:0]
//   shadow_hi        : snapshot bits [31:8] (zero beyond CNT_W)
module xilly_beat_counter #(
  parameter int CNT_W = 32
) (
  input  logic        bus_clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        inc,
  input  logic        snap,
  output logic [7:0]  count_lo,
  output logic [23:0] shadow_hi
);

  logic [CNT_W-1:0] cnt_r;
  logic [23:0]      shadow_r;
  logic [31:0]      count_full_s;

  assign count_full_s = 32'(cnt_r);
  assign count_lo     = count_full_s[7:0];
  assign shadow_hi    = shadow_r;

  // Beat counter: clear has priority so a same-cycle beat is lost to the clear.
  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Shadow of the upper bytes, taken when the low byte is read; survives clr.
  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      shadow_r <= 24'h000000;
    end else if (snap) begin
      shadow_r <= count_full_s[31:8];
    end else begin
      shadow_r <= shadow_r;
    end
  end

endmodule

// File: rtl/xilly_accel_bridge.sv
// xilly_accel_bridge
// Control and stream glue between the Xillybus core and an accelerator.
// Ports:
//   bus_clk, reset_n : clock, synchronous active-low reset
//   bus (slave)      : mem register port, select handshake, input stream
//                      (FWFT FIFO -> accelerator), output stream
//                      (accelerator -> FIFO); see xilly_accel_bridge_if
// Register map: 0 CTRL, 1 SELECT, 2 ACK_COUNT, 4..7 IN_BEATS,
// 8..11 OUT_BEATS, 12..15 SCRATCH; all other addresses read 0.
module xilly_accel_bridge
  import xilly_accel_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int PIX_W      = 24,
  parameter int RST_CYCLES = 16,
  parameter int CNT_W      = 32,
  parameter int TAG_OUT    = 1
) (
  input  logic                 bus_clk,
  input  logic                 reset_n,
  xilly_accel_bridge_if.slave  bus
);

  localparam int PULSE_W = $clog2(RST_CYCLES + 1);

  logic [PULSE_W-1:0] pulse_cnt_r;
  logic               sel_pending_r;
  logic [7:0]         select_r;
  logic [7:0]         ack_cnt_r;
  logic [7:0]         rdata_r;
  logic [31:0]        scratch_r;

  logic [31:0] addr_s;
  logic        pulse_active_s;
  logic        pulse_end_s;
  logic        wr_ctrl_s;
  logic        wr_select_s;
  logic        wr_scratch_s;
  logic        restart_s;
  logic        clear_s;
  logic        sel_valid_s;
  logic        handshake_s;
  logic        acc_in_valid_s;
  logic        in_xfer_s;
  logic        acc_out_ready_s;
  logic        out_xfer_s;
  logic        snap_in_s;
  logic        snap_out_s;
  logic [7:0]  in_lo_s;
  logic [23:0] in_shadow_s;
  logic [7:0]  out_lo_s;
  logic [23:0] out_shadow_s;
  logic [7:0]  tag_s;
  logic [7:0]  rd_mux_s;
  logic        unused_s;

  // Address decode, handshake and stream qualification.
  always_comb begin
    addr_s          = 32'(bus.mem_addr);
    pulse_active_s  = (pulse_cnt_r != {PULSE_W{1'b0}});
    wr_ctrl_s       = bus.mem_wren && (addr_s == ADDR_CTRL);
    wr_select_s     = bus.mem_wren && (addr_s == ADDR_SELECT);
    wr_scratch_s    = bus.mem_wren && (addr_s[31:2] == ADDR_SCRATCH[31:2]);
    restart_s       = wr_ctrl_s && bus.mem_wdata[CTRL_RESTART_BIT];
    clear_s         = wr_ctrl_s && bus.mem_wdata[CTRL_CLEAR_BIT];
    // Last active cycle of the pulse, unless a restart extends it.
    pulse_end_s     = (pulse_cnt_r == PULSE_W'(1)) && !restart_s;
    sel_valid_s     = sel_pending_r && !pulse_active_s;
    handshake_s     = sel_valid_s && bus.sel_ready;
    acc_in_valid_s  = bus.in_fifo_valid && !pulse_active_s;
    in_xfer_s       = acc_in_valid_s && bus.acc_in_ready;
    acc_out_ready_s = !bus.out_fifo_full && !pulse_active_s;
    out_xfer_s      = bus.acc_out_valid && acc_out_ready_s;
    snap_in_s       = bus.mem_rden && (addr_s == ADDR_IN_BEATS);
    snap_out_s      = bus.mem_rden && (addr_s == ADDR_OUT_BEATS);
    tag_s           = (TAG_OUT != 0) ? select_r : 8'h00;
  end

  assign bus.accel_reset   = pulse_active_s;
  assign bus.sel_valid     = sel_valid_s;
  assign bus.sel_bits      = select_r;
  assign bus.acc_in_valid  = acc_in_valid_s;
  assign bus.acc_in_bits   = bus.in_fifo_data[PIX_W-1:0];
  assign bus.in_fifo_rd    = in_xfer_s;
  assign bus.acc_out_ready = acc_out_ready_s;
  assign bus.out_fifo_wren = out_xfer_s;
  assign bus.out_fifo_data = {tag_s, 24'h000000} | 32'(bus.acc_out_bits);
  assign bus.mem_rdata     = rdata_r;
  // FIFO bits above PIX_W are intentionally dropped.
  assign unused_s          = ^bus.in_fifo_data;

  // Accelerator reset pulse: loaded in reset and by CTRL restart, counts down to 0.
  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      pulse_cnt_r <= PULSE_W'(RST_CYCLES);
    end else if (restart_s) begin
      pulse_cnt_r <= PULSE_W'(RST_CYCLES);
    end else if (pulse_active_s) begin
      pulse_cnt_r <= pulse_cnt_r - PULSE_W'(1);
    end else begin
      pulse_cnt_r <= pulse_cnt_r;
    end
  end

  // SELECT register, pending flag and handshake counter.
  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      select_r      <= 8'h00;
      sel_pending_r <= 1'b0;
      ack_cnt_r     <= 8'h00;
    end else begin
      if (wr_select_s) begin
        select_r <= bus.mem_wdata;
      end else begin
        select_r <= select_r;
      end
      // A new SELECT or a freshly reset accelerator needs a (re)issue; this
      // wins over a same-cycle handshake so the new value is still presented.
      if (wr_select_s || pulse_end_s) begin
        sel_pending_r <= 1'b1;
      end else if (handshake_s) begin
        sel_pending_r <= 1'b0;
      end else begin
        sel_pending_r <= sel_pending_r;
      end
      if (handshake_s) begin
        ack_cnt_r <= ack_cnt_r + 8'd1;
      end else begin
        ack_cnt_r <= ack_cnt_r;
      end
    end
  end

  // Scratch register, one byte lane per write.
  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      scratch_r <= 32'h00000000;
    end else if (wr_scratch_s) begin
      case (addr_s[1:0])
        2'd0:    scratch_r[7:0]   <= bus.mem_wdata;
        2'd1:    scratch_r[15:8]  <= bus.mem_wdata;
        2'd2:    scratch_r[23:16] <= bus.mem_wdata;
        2'd3:    scratch_r[31:24] <= bus.mem_wdata;
        default: scratch_r        <= scratch_r;
      endcase
    end else begin
      scratch_r <= scratch_r;
    end
  end

  // Read multiplexer over the current (pre-write) register values.
  always_comb begin
    rd_mux_s = 8'h00;
    case (addr_s)
      ADDR_CTRL:              rd_mux_s = {6'b000000, sel_pending_r, pulse_active_s};
      ADDR_SELECT:            rd_mux_s = select_r;
      ADDR_ACK:               rd_mux_s = ack_cnt_r;
      ADDR_IN_BEATS:          rd_mux_s = in_lo_s;
      ADDR_IN_BEATS + 32'd1:  rd_mux_s = in_shadow_s[7:0];
      ADDR_IN_BEATS + 32'd2:  rd_mux_s = in_shadow_s[15:8];
      ADDR_IN_BEATS + 32'd3:  rd_mux_s = in_shadow_s[23:16];
      ADDR_OUT_BEATS:         rd_mux_s = out_lo_s;
      ADDR_OUT_BEATS + 32'd1: rd_mux_s = out_shadow_s[7:0];
      ADDR_OUT_BEATS + 32'd2: rd_mux_s = out_shadow_s[15:8];
      ADDR_OUT_BEATS + 32'd3: rd_mux_s = out_shadow_s[23:16];
      ADDR_SCRATCH,
      ADDR_SCRATCH + 32'd1,
      ADDR_SCRATCH + 32'd2,
      ADDR_SCRATCH + 32'd3:   rd_mux_s = byte_of(scratch_r, addr_s[1:0]);
      default:                rd_mux_s = 8'h00;
    endcase
  end

  // Registered read data: updates only on a read strobe.
  always_ff @(posedge bus_clk) begin
    if (!reset_n) begin
      rdata_r <= 8'h00;
    end else if (bus.mem_rden) begin
      rdata_r <= rd_mux_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  xilly_beat_counter #(.CNT_W(CNT_W)) u_in_beats (
    .bus_clk   (bus_clk),
    .reset_n   (reset_n),
    .clr       (clear_s),
    .inc       (in_xfer_s),
    .snap      (snap_in_s),
    .count_lo  (in_lo_s),
    .shadow_hi (in_shadow_s)
  );

  xilly_beat_counter #(.CNT_W(CNT_W)) u_out_beats (
    .bus_clk   (bus_clk),
    .reset_n   (reset_n),
    .clr       (clear_s),
    .inc       (out_xfer_s),
    .snap      (snap_out_s),
    .count_lo  (out_lo_s),
    .shadow_hi (out_shadow_s)
  );

endmodule

// File: tb/tb_xilly_accel_bridge.sv
// tb_xilly_accel_bridge
// Directed bench: plays the Xillybus core (mem port, FWFT input FIFO, output
// FIFO) and a small queue-based accelerator. Expected output words are queued
// when input words are consumed and compared when the bridge pushes them out.
module tb_xilly_accel_bridge;

  localparam int ADDR_W     = 5;
  localparam int PIX_W      = 24;
  localparam int RST_CYCLES = 16;
  localparam int CNT_W      = 32;
  localparam int TAG_OUT    = 1;

  logic bus_clk = 1'b0;
  logic reset_n;

  always #5 bus_clk = ~bus_clk;

  xilly_accel_bridge_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus_i ();

  xilly_accel_bridge #(
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .RST_CYCLES(RST_CYCLES),
    .CNT_W(CNT_W), .TAG_OUT(TAG_OUT)
  ) dut (
    .bus_clk (bus_clk),
    .reset_n (reset_n),
    .bus     (bus_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]      exp_q[$];
  logic [PIX_W-1:0] acc_q[$];
  int in_idx, in_total, out_count, hs_cnt;
  logic tgl, steady_ready;
  logic [7:0] sel_model;

  logic s_accel_reset, s_sel_valid, s_sel_ready, s_in_rd, s_acc_in_valid;
  logic s_acc_out_ready, s_out_wr, s_full;
  logic [7:0]       s_sel_bits;
  logic [31:0]      s_out_data;
  logic [PIX_W-1:0] s_in_bits;

  function automatic logic [31:0] word_of(input int i);
    return 32'hC3000000 ^ (32'(i) * 32'h00010203);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_models();
    bus_i.in_fifo_valid = (in_idx < in_total);
    bus_i.in_fifo_data  = word_of(in_idx);
    bus_i.acc_in_ready  = (steady_ready || tgl) && (acc_q.size() < 4);
    bus_i.acc_out_valid = (acc_q.size() > 0);
    bus_i.acc_out_bits  = (acc_q.size() > 0) ? acc_q[0] : {PIX_W{1'b0}};
  endtask

  // One clock: sample at negedge, then update models just after posedge.
  task automatic tick();
    logic [31:0] w;
    logic [31:0] e;
    @(negedge bus_clk);
    s_accel_reset   = bus_i.accel_reset;
    s_sel_valid     = bus_i.sel_valid;
    s_sel_ready     = bus_i.sel_ready;
    s_sel_bits      = bus_i.sel_bits;
    s_in_rd         = bus_i.in_fifo_rd;
    s_acc_in_valid  = bus_i.acc_in_valid;
    s_in_bits       = bus_i.acc_in_bits;
    s_acc_out_ready = bus_i.acc_out_ready;
    s_out_wr        = bus_i.out_fifo_wren;
    s_out_data      = bus_i.out_fifo_data;
    s_full          = bus_i.out_fifo_full;
    if (s_full) chk("stall_on_full", 32'(s_acc_out_ready), 32'd0);
    if (s_out_wr) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_bad++;
        $error("FAIL sb_extra_word: observed 0x%08h expected no word", s_out_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_out_word", s_out_data, e);
      end
      out_count++;
    end
    if (s_sel_valid && s_sel_ready) hs_cnt++;
    @(posedge bus_clk);
    #1;
    if (s_in_rd) begin
      w = word_of(in_idx);
      chk("acc_in_bits", 32'(s_in_bits), {8'h00, w[23:0]});
      acc_q.push_back(s_in_bits);
      exp_q.push_back({sel_model, w[23:0]});
      in_idx++;
    end
    if (s_out_wr && acc_q.size() > 0) void'(acc_q.pop_front());
    tgl = ~tgl;
    drive_models();
  endtask

  task automatic mem_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    bus_i.mem_addr  = a;
    bus_i.mem_wdata = d;
    bus_i.mem_wren  = 1'b1;
    tick();
    bus_i.mem_wren  = 1'b0;
  endtask

  task automatic mem_read(input logic [ADDR_W-1:0] a, output logic [7:0] d);
    bus_i.mem_addr = a;
    bus_i.mem_rden = 1'b1;
    tick();
    bus_i.mem_rden = 1'b0;
    d = bus_i.mem_rdata;
  endtask

  task automatic read_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    mem_read(a, d);
    chk(tag, 32'(d), 32'(exp));
  endtask

  // Run the stream until `target` words have left; optional 20-cycle full window.
  task automatic run_stream(input int target, input int full_start);
    int cyc;
    cyc = 0;
    in_total = target;
    drive_models();
    while (out_count < target && cyc < 4000) begin
      bus_i.out_fifo_full = (full_start >= 0) && (cyc >= full_start) && (cyc < full_start + 20);
      tick();
      cyc++;
    end
    bus_i.out_fifo_full = 1'b0;
    chk("stream_complete", 32'(out_count), 32'(target));
    chk("stream_in_count", 32'(in_idx), 32'(target));
  endtask

  // Count consecutive sampled accel_reset cycles, checking the stall rules.
  task automatic measure_pulse(output int n);
    n = 0;
    tick();
    while (s_accel_reset && n < 40) begin
      chk("pulse_in_rd", 32'(s_in_rd), 32'd0);
      chk("pulse_acc_in_valid", 32'(s_acc_in_valid), 32'd0);
      chk("pulse_sel_valid", 32'(s_sel_valid), 32'd0);
      chk("pulse_acc_out_ready", 32'(s_acc_out_ready), 32'd0);
      n++;
      tick();
    end
  endtask

  initial begin
    int n, hs0, out_mark;
    logic [7:0] d;

    reset_n = 1'b0;
    bus_i.mem_addr = '0;  bus_i.mem_wren = 1'b0; bus_i.mem_wdata = 8'h00;
    bus_i.mem_rden = 1'b0; bus_i.sel_ready = 1'b0; bus_i.out_fifo_full = 1'b0;
    in_idx = 0; in_total = 0; out_count = 0; hs_cnt = 0;
    tgl = 1'b0; steady_ready = 1'b0; sel_model = 8'h00;
    drive_models();

    // Reset state
    repeat (4) tick();
    chk("rst_accel_reset", 32'(s_accel_reset), 32'd1);
    chk("rst_sel_valid", 32'(s_sel_valid), 32'd0);
    chk("rst_acc_out_ready", 32'(s_acc_out_ready), 32'd0);
    chk("rst_mem_rdata", 32'(bus_i.mem_rdata), 32'd0);
    tick();
    reset_n = 1'b1;

    // 1: pulse extends 16 cycles past release, then SELECT=0 is issued once
    measure_pulse(n);
    chk("t1_pulse_len", 32'(n), 32'd16);
    chk("t1_sel_valid", 32'(s_sel_valid), 32'd1);
    chk("t1_sel_bits", 32'(s_sel_bits), 32'd0);
    bus_i.sel_ready = 1'b1;
    tick();
    bus_i.sel_ready = 1'b0;
    chk("t1_hs_cnt", 32'(hs_cnt), 32'd1);
    read_chk("t1_ack", 5'd2, 8'd1);

    // 2: SELECT=8 held 10 cycles, single handshake
    mem_write(5'd1, 8'h08);
    sel_model = 8'h08;
    hs0 = hs_cnt;
    n = 0;
    repeat (10) begin
      tick();
      if (s_sel_valid && s_sel_bits == 8'h08) n++;
    end
    chk("t2_sel_held", 32'(n), 32'd10);
    bus_i.sel_ready = 1'b1;
    tick();
    bus_i.sel_ready = 1'b0;
    tick();
    chk("t2_sel_dropped", 32'(s_sel_valid), 32'd0);
    chk("t2_single_hs", 32'(hs_cnt - hs0), 32'd1);
    read_chk("t2_ack", 5'd2, 8'd2);
    read_chk("t2_ctrl", 5'd0, 8'h00);

    // 3: 300 words with toggling ready and a full window mid-stream
    run_stream(300, 60);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    read_chk("t3_in_b0", 5'd4, 8'h2C);
    read_chk("t3_in_b1", 5'd5, 8'h01);
    read_chk("t3_in_b2", 5'd6, 8'h00);
    read_chk("t3_in_b3", 5'd7, 8'h00);
    read_chk("t3_out_b0", 5'd8, 8'h2C);
    read_chk("t3_out_b1", 5'd9, 8'h01);

    // 4: snapshot at 0x1FE, live counter moves to 0x201
    run_stream(510, -1);
    read_chk("t4_snap_b0", 5'd4, 8'hFE);
    run_stream(513, -1);
    read_chk("t4_shadow_b1", 5'd5, 8'h01);
    read_chk("t4_shadow_b2", 5'd6, 8'h00);
    read_chk("t4_shadow_b3", 5'd7, 8'h00);
    read_chk("t4_live_b0", 5'd4, 8'h01);
    read_chk("t4_new_b1", 5'd5, 8'h02);

    // 5: CTRL restart mid-stream
    in_total = 553;
    drive_models();
    repeat (6) tick();
    chk("t5_stream_active", 32'(s_acc_in_valid), 32'd1);
    mem_write(5'd0, 8'h01);
    measure_pulse(n);
    chk("t5_pulse_len", 32'(n), 32'd16);
    chk("t5_reissue_valid", 32'(s_sel_valid), 32'd1);
    chk("t5_reissue_bits", 32'(s_sel_bits), 32'd8);
    bus_i.sel_ready = 1'b1;
    tick();
    bus_i.sel_ready = 1'b0;
    read_chk("t5_ack", 5'd2, 8'd3);
    run_stream(553, -1);
    read_chk("t5_in_b0", 5'd4, 8'h29);
    read_chk("t5_in_b1", 5'd5, 8'h02);
    read_chk("t5_out_b0", 5'd8, 8'h29);
    read_chk("t5_out_b1", 5'd9, 8'h02);

    // 6: clear coincident with an input transfer; scratch; unmapped
    steady_ready = 1'b1;
    in_total = in_idx + 1000;
    drive_models();
    repeat (4) tick();
    mem_write(5'd0, 8'h02);
    chk("t6_clear_with_xfer", 32'(s_in_rd), 32'd1);
    out_mark = out_count;
    run_stream(in_idx, -1);
    steady_ready = 1'b0;
    read_chk("t6_in_b0", 5'd4, 8'h00);
    read_chk("t6_in_b1", 5'd5, 8'h00);
    read_chk("t6_out_b0", 5'd8, 8'(out_count - out_mark));
    mem_write(5'd13, 8'hA5);
    read_chk("t6_scratch13", 5'd13, 8'hA5);
    read_chk("t6_scratch12", 5'd12, 8'h00);
    read_chk("t6_unmapped20", 5'd20, 8'h00);
    bus_i.mem_addr  = 5'd14;
    bus_i.mem_wdata = 8'h3C;
    bus_i.mem_wren  = 1'b1;
    bus_i.mem_rden  = 1'b1;
    tick();
    bus_i.mem_wren  = 1'b0;
    bus_i.mem_rden  = 1'b0;
    chk("t6_rw_same_cycle_old", 32'(bus_i.mem_rdata), 32'd0);
    read_chk("t6_scratch14", 5'd14, 8'h3C);
    read_chk("t6_rdata_hold_src", 5'd1, 8'h08);
    repeat (2) tick();
    chk("t6_rdata_hold", 32'(bus_i.mem_rdata), 32'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion expected finish before 1000000 ns");
    $fatal(1, "watchdog");
  end

endmodule
